// File: rtl/ysyx_22051145_redir_pkg.sv
// Shared constants, state encoding and target-formation helper for the
// redirect controller slice.
package ysyx_22051145_redir_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned MAX_OUTST = 3;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    // jalr-style bit-0 clear, applied to every redirect source
    function automatic logic [XLEN-1:0] redir_tgt(input logic [XLEN-1:0] t);
        return {t[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_22051145_redirect_ctrl_if.sv
// IFU-facing bundle: redirect handshake plus fetch request/response tracking.
interface ysyx_22051145_redirect_ctrl_if
    import ysyx_22051145_redir_pkg::*;
();

    logic            redir_valid;
    logic [XLEN-1:0] redir_addr;
    logic            redir_ready;
    logic            if_req_fire;
    logic            if_rsp_fire;
    logic            rsp_discard;

    modport master (
        output redir_valid, redir_addr, rsp_discard,
        input  redir_ready, if_req_fire, if_rsp_fire
    );

    modport slave (
        input  redir_valid, redir_addr, rsp_discard,
        output redir_ready, if_req_fire, if_rsp_fire
    );

endinterface

// File: rtl/ysyx_22051145_outst_cnt.sv
// Small up/down counter with synchronous load; exposes both the current and
// the next value so callers can act on this cycle's events.
module ysyx_22051145_outst_cnt
    import ysyx_22051145_redir_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/ysyx_22051145_redirect_ctrl.sv
// Sequences jump/trap redirects to the IFU, flushes the front end, stalls EX
// while a redirect is pending and discards fetch responses made stale by it.
module ysyx_22051145_redirect_ctrl
    import ysyx_22051145_redir_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            flush,
    output logic            ex_stall,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    ysyx_22051145_redirect_ctrl_if.master ifu_bus
);

    state_e          state_q, state_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_addr_q, redir_addr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic             req, rsp, ready;
    logic             disc_load, discard;
    logic [CNT_W-1:0] outst_cnt, outst_next, disc_cnt, disc_next;

    assign req   = ifu_bus.if_req_fire;
    assign rsp   = ifu_bus.if_rsp_fire;
    assign ready = ifu_bus.redir_ready;

    ysyx_22051145_outst_cnt #(.W(CNT_W)) u_outst (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (req),
        .dec_i      (rsp),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (outst_cnt),
        .cnt_next_o (outst_next)
    );

    ysyx_22051145_outst_cnt #(.W(CNT_W)) u_discard (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (1'b0),
        .dec_i      (discard),
        .load_i     (disc_load),
        .load_val_i (outst_next),
        .cnt_o      (disc_cnt),
        .cnt_next_o (disc_next)
    );

    assign discard  = (state_q == ST_DRAIN) && rsp && (disc_cnt != '0);
    assign ex_stall = (state_q == ST_REDIRECT);

    always_comb begin
        state_d         = state_q;
        redir_valid_d   = redir_valid_q;
        redir_addr_d    = redir_addr_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        flush           = 1'b0;
        disc_load       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (trap_valid) begin
                    flush         = 1'b1;
                    redir_valid_d = 1'b1;
                    redir_addr_d  = redir_tgt(trap_target);
                    state_d       = ST_REDIRECT;
                end else if (ex_valid && ex_jump) begin
                    if (ex_target[1]) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex_target;
                    end else begin
                        flush         = 1'b1;
                        redir_valid_d = 1'b1;
                        redir_addr_d  = redir_tgt(ex_target);
                        state_d       = ST_REDIRECT;
                    end
                end else if (state_q == ST_DRAIN && disc_next == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (trap_valid) begin
                    flush        = 1'b1;
                    redir_addr_d = redir_tgt(trap_target);
                end
                // a trap coinciding with the handshake re-arms the request
                if (ready) begin
                    disc_load = 1'b1;
                    if (!trap_valid) begin
                        redir_valid_d = 1'b0;
                        state_d       = (outst_next != '0) ? ST_DRAIN : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            redir_valid_q   <= 1'b0;
            redir_addr_q    <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            redir_valid_q   <= redir_valid_d;
            redir_addr_q    <= redir_addr_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign ifu_bus.redir_valid = redir_valid_q;
    assign ifu_bus.redir_addr  = redir_addr_q;
    assign ifu_bus.rsp_discard = discard;
    assign misalign            = misalign_q;
    assign misalign_addr       = misalign_addr_q;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(req && !rsp && outst_cnt == CNT_W'(MAX_OUTST)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp && !req && outst_cnt == '0));
`endif

endmodule

// File: tb/tb_ysyx_22051145_redirect_ctrl.sv
// Directed bench for the redirect controller: an abstract pending/stale-count
// model checked every cycle, plus hand-computed spot checks.
module tb_ysyx_22051145_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_jump, trap_valid;
    logic [63:0] ex_target, trap_target;
    logic        flush, ex_stall, misalign;
    logic [63:0] misalign_addr;

    ysyx_22051145_redirect_ctrl_if ifc ();

    ysyx_22051145_redirect_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_jump       (ex_jump),
        .ex_target     (ex_target),
        .trap_valid    (trap_valid),
        .trap_target   (trap_target),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .ifu_bus       (ifc.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: a redirect is either pending or not; stale counts responses to drop.
    bit          m_pend, m_mis;
    logic [63:0] m_addr, m_mis_addr;
    int          m_out, m_stale;

    always @(negedge clk) begin : model
        int          onext;
        logic        jmp;
        if (!rst_n) begin
            m_pend = 0; m_mis = 0; m_addr = 64'h0; m_mis_addr = 64'h0;
            m_out = 0; m_stale = 0;
        end else begin
            jmp = ex_valid && ex_jump;
            chk1("m_flush", flush, trap_valid || (!m_pend && jmp && !ex_target[1]));
            chk1("m_stall", ex_stall, m_pend);
            chk1("m_valid", ifc.redir_valid, m_pend);
            chk64("m_addr", ifc.redir_addr, m_addr);
            chk1("m_misalign", misalign, m_mis);
            if (m_mis) chk64("m_mis_addr", misalign_addr, m_mis_addr);
            chk1("m_discard", ifc.rsp_discard, !m_pend && ifc.if_rsp_fire && (m_stale > 0));

            onext = m_out + int'(ifc.if_req_fire) - int'(ifc.if_rsp_fire);
            m_mis = 0;
            if (!m_pend) begin
                if (ifc.if_rsp_fire && m_stale > 0) m_stale = m_stale - 1;
                if (trap_valid) begin
                    m_pend = 1; m_addr = trap_target & ~64'h1;
                end else if (jmp && ex_target[1]) begin
                    m_mis = 1; m_mis_addr = ex_target;
                end else if (jmp) begin
                    m_pend = 1; m_addr = ex_target & ~64'h1;
                end
            end else begin
                if (trap_valid) m_addr = trap_target & ~64'h1;
                if (ifc.redir_ready) begin
                    m_stale = onext;
                    if (!trap_valid) m_pend = 0;
                end
            end
            m_out = onext;
        end
    end

    task automatic setin(input logic v, input logic j, input logic [63:0] t,
                         input logic tv, input logic [63:0] tt,
                         input logic rdy, input logic rq, input logic rs);
        ex_valid = v; ex_jump = j; ex_target = t;
        trap_valid = tv; trap_target = tt;
        ifc.redir_ready = rdy; ifc.if_req_fire = rq; ifc.if_rsp_fire = rs;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int   stalls;
        logic exp_disc [3];
        exp_disc = '{1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        mid();
        chk1("rst_valid", ifc.redir_valid, 1'b0);
        chk64("rst_addr", ifc.redir_addr, 64'h0);
        chk1("rst_misalign", misalign, 1'b0);
        chk64("rst_mis_addr", misalign_addr, 64'h0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_stall", ex_stall, 1'b0);
        chk1("rst_discard", ifc.rsp_discard, 1'b0);
        cyc();
        rst_n = 1'b1;

        // jal, ready held high
        setin(1'b1, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        mid(); chk1("t1_flush", flush, 1'b1); chk1("t1_stall0", ex_stall, 1'b0); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        mid();
        chk1("t1_valid", ifc.redir_valid, 1'b1);
        chk64("t1_addr", ifc.redir_addr, 64'h8000_0010);
        chk1("t1_stall1", ex_stall, 1'b1);
        cyc();
        mid(); chk1("t1_stall_done", ex_stall, 1'b0); chk1("t1_valid_done", ifc.redir_valid, 1'b0); cyc();

        // jalr with odd target, IFU not ready for 3 cycles; a second jump is ignored
        setin(1'b1, 1'b1, 64'h8000_0021, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t2_flush", flush, 1'b1); cyc();
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            setin(i == 1, i == 1, 64'h9000_0000, 1'b0, 64'h0, i == 3, 1'b0, 1'b0);
            mid();
            if (ex_stall) stalls++;
            if (i < 4) chk64("t2_addr_hold", ifc.redir_addr, 64'h8000_0020);
            if (i == 1) chk1("t2_jump_ignored", flush, 1'b0);
            cyc();
        end
        chk64("t2_stall_cycles", 64'(stalls), 64'(4));

        // misaligned target
        setin(1'b1, 1'b1, 64'h8000_0022, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t3_noflush", flush, 1'b0); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid();
        chk1("t3_misalign", misalign, 1'b1);
        chk64("t3_mis_addr", misalign_addr, 64'h8000_0022);
        chk1("t3_novalid", ifc.redir_valid, 1'b0);
        cyc();
        mid(); chk1("t3_pulse_end", misalign, 1'b0); cyc();

        // trap beats jump in the same cycle
        setin(1'b1, 1'b1, 64'h8000_0040, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
        mid(); chk1("t4_flush", flush, 1'b1); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        mid(); chk64("t4_addr", ifc.redir_addr, 64'h8000_0100); cyc();

        // trap overrides a pending redirect; trap together with ready re-arms
        setin(1'b1, 1'b1, 64'h8000_0200, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0301, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t4b_trap_flush", flush, 1'b1); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0400, 1'b1, 1'b0, 1'b0);
        mid(); chk64("t4b_addr_trap", ifc.redir_addr, 64'h8000_0300); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        mid();
        chk64("t4b_addr_rearm", ifc.redir_addr, 64'h8000_0400);
        chk1("t4b_valid_rearm", ifc.redir_valid, 1'b1);
        cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t4b_done", ifc.redir_valid, 1'b0); cyc();

        // two fetches in flight when the redirect is accepted
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0); mid(); cyc();
        mid(); cyc();
        setin(1'b1, 1'b1, 64'h8000_0500, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t5_flush", flush, 1'b1); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        mid(); chk1("t5_stall", ex_stall, 1'b1); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        mid(); chk1("t5_drain_nostall", ex_stall, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
            mid(); chk1($sformatf("t5_discard%0d", i), ifc.rsp_discard, exp_disc[i]); cyc();
        end
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); cyc();

        // reset while a redirect is pending
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0); mid(); cyc();
        setin(1'b1, 1'b1, 64'h8000_0600, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0); mid(); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); chk1("t6_pending", ifc.redir_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t6_rst_valid", ifc.redir_valid, 1'b0);
        chk1("t6_rst_stall", ex_stall, 1'b0);
        chk64("t6_rst_addr", ifc.redir_addr, 64'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        mid();
        chk1("t6_post_flush", flush, 1'b0);
        chk1("t6_post_stall", ex_stall, 1'b0);
        cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0); mid(); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        mid(); chk1("t6_no_discard", ifc.rsp_discard, 1'b0); cyc();
        setin(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        mid(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
